// File: rtl/dma_pkg.sv
// Shared AXI read constants and the read-engine state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dma_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    // AXI bursts must not cross a 4 KB page.
    localparam int unsigned PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        RDATA,
        FLUSH,
        DONE
    } rd_state_t;

endpackage

// File: rtl/rd_pack_32_to_128.sv
// Packs four 32-bit read beats into one 128-bit word (beat0 in the low lane).
// Latency: word visible on word_vld the cycle after its 4th beat is taken.
// Backpressure: beat_rdy drops only when a 4th beat arrives while the output word is held.
//
// Ports: beat_vld/beat_dat/beat_last  - accepted beat, last marks final beat of the transfer
//        flush                        - drop the partially packed word (error path)
//        beat_rdy                     - beat can be taken this cycle
//        word_dat/word_vld/word_last  - packed output word, held until word_rdy
module rd_pack_32_to_128
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 128
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_vld,
    input  logic [DATA_WIDTH-1:0] beat_dat,
    input  logic                  beat_last,
    input  logic                  flush,
    output logic                  beat_rdy,
    output logic [OUT_WIDTH-1:0]  word_dat,
    output logic                  word_vld,
    output logic                  word_last,
    input  logic                  word_rdy
);

    // Only lanes 0..2 are stored; the 4th beat goes straight into the output word.
    logic [DATA_WIDTH-1:0] lane [3];
    logic [1:0]            pack_idx;

    assign beat_rdy = !(pack_idx == 2'd3 && word_vld && !word_rdy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane      <= '{default: '0};
            pack_idx  <= 2'd0;
            word_dat  <= '0;
            word_vld  <= 1'b0;
            word_last <= 1'b0;
        end else begin
            if (word_vld && word_rdy) begin
                word_vld  <= 1'b0;
                word_last <= 1'b0;
            end
            if (flush) begin
                pack_idx <= 2'd0;
            end else if (beat_vld) begin
                pack_idx <= pack_idx + 2'd1;
                if (pack_idx == 2'd3) begin
                    // Loading here overrides the clear above, so a word can
                    // replace one being accepted in the same cycle.
                    word_dat  <= {beat_dat, lane[2], lane[1], lane[0]};
                    word_vld  <= 1'b1;
                    word_last <= beat_last;
                end else begin
                    lane[pack_idx] <= beat_dat;
                end
            end
        end
    end

endmodule

// File: rtl/dma_read_engine.sv
// AXI4 read master: fetches len/16 words from base and emits them as packed 128-bit words.
// Latency: AR issued 2 cycles after start; each word appears 1 cycle after its 4th beat.
// Backpressure: i_ready low stalls rready only when a 4th beat finds the output word full.
//
// Ports: clk/rst_n (sync active-low), i_start/i_base_addr/i_total_len job programming,
//        o_busy/o_done/o_error status, m_axi_ar*/m_axi_r* AXI read channels,
//        o_data/o_valid/o_last/i_ready packed output stream.
module dma_read_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 128,
    parameter int MAX_BURST  = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [31:0]           i_total_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    localparam int unsigned PAGE_BEATS = PAGE_BYTES / 4;

    // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page end.
    function automatic logic [8:0] burst_beats(input logic [9:0] page_word, input logic [29:0] left);
        logic [29:0] n;
        logic [29:0] page_left;
        page_left = 30'(PAGE_BEATS) - 30'(page_word);
        n = 30'(MAX_BURST);
        if (left < n)      n = left;
        if (page_left < n) n = page_left;
        return 9'(n);
    endfunction

    rd_state_t             state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [29:0]           beats_left;
    logic [8:0]            burst_cnt;
    logic                  discard;

    logic pack_rdy;
    logic beat_acc;
    logic is_final;
    logic beat_bad;
    logic burst_end;

    // Low address bits and sub-word length bits are don't-care by definition.
    logic unused_bits;
    assign unused_bits = ^{i_base_addr[1:0], i_total_len[3:0]};

    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;

    // While discarding after an error the beats never reach the packer, so
    // rready stays high regardless of the output side.
    assign m_axi_rready = (state == RDATA) && (discard || pack_rdy);

    assign beat_acc  = (state == RDATA) && m_axi_rvalid && m_axi_rready;
    assign is_final  = (burst_cnt == 9'd1);
    // The local beat counter is authoritative; rlast disagreeing with it is an error.
    assign beat_bad  = beat_acc && (m_axi_rresp[1] || (m_axi_rlast != is_final));
    assign burst_end = is_final || m_axi_rlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            beats_left    <= '0;
            burst_cnt     <= '0;
            discard       <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arlen   <= '0;
            m_axi_arvalid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        addr       <= {i_base_addr[ADDR_WIDTH-1:2], 2'b00};
                        beats_left <= {i_total_len[31:4], 2'b00};
                        discard    <= 1'b0;
                        o_error    <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= (i_total_len[31:4] == '0) ? DONE : AR;
                    end
                end
                AR: begin
                    // First cycle computes and registers the request; it then
                    // holds stable until the slave takes it.
                    if (!m_axi_arvalid) begin
                        m_axi_araddr  <= addr;
                        m_axi_arlen   <= 8'(burst_beats(addr[11:2], beats_left) - 9'd1);
                        m_axi_arvalid <= 1'b1;
                    end else if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        burst_cnt     <= 9'(m_axi_arlen) + 9'd1;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (beat_acc) begin
                        burst_cnt  <= burst_cnt - 9'd1;
                        beats_left <= beats_left - 30'd1;
                        if (beat_bad) begin
                            o_error <= 1'b1;
                            discard <= 1'b1;
                        end
                        if (burst_end) begin
                            if (discard || beat_bad || beats_left == 30'd1) begin
                                state <= FLUSH;
                            end else begin
                                addr  <= m_axi_araddr + ADDR_WIDTH'({9'(m_axi_arlen) + 9'd1, 2'b00});
                                state <= AR;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (!o_valid || i_ready) state <= DONE;
                end
                DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_pack_32_to_128 #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .beat_vld  (beat_acc && !beat_bad && !discard),
        .beat_dat  (m_axi_rdata),
        .beat_last (beats_left == 30'd1),
        .flush     (beat_bad),
        .beat_rdy  (pack_rdy),
        .word_dat  (o_data),
        .word_vld  (o_valid),
        .word_last (o_last),
        .word_rdy  (i_ready)
    );

endmodule

// File: tb/tb_dma_read_engine.sv
module tb_dma_read_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [31:0]  i_base_addr;
    logic [31:0]  i_total_len;
    logic         o_busy, o_done, o_error;
    logic [31:0]  m_axi_araddr;
    logic [7:0]   m_axi_arlen;
    logic [2:0]   m_axi_arsize;
    logic [1:0]   m_axi_arburst;
    logic         m_axi_arvalid, m_axi_arready;
    logic [31:0]  m_axi_rdata;
    logic [1:0]   m_axi_rresp;
    logic         m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [127:0] o_data;
    logic         o_valid, o_last, i_ready;

    always #5 clk = ~clk;

    dma_read_engine dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_total_len(i_total_len), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready)
    );

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic exp_err = 1'b0;

    logic [31:0] job_base = '0;
    logic [31:0] job_tag  = '0;
    int job_beat = 0;
    int err_beat = -1;
    int taken    = 0;
    int rdy_low  = 0;
    int rdy_cyc  = 0;
    bit rdy_mode = 1'b0;
    bit rdy_chk  = 1'b0;
    bit pat [4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [39:0]  exp_ar [$];
    logic [128:0] exp_q  [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected words: beat k of a job carries tag + k; four beats per word.
    task automatic push_words(input logic [31:0] tag, input int n, input bit last_on_final);
        logic [128:0] e;
        for (int w = 0; w < n; w++) begin
            e[31:0]   = tag + 32'(4*w);
            e[63:32]  = tag + 32'(4*w + 1);
            e[95:64]  = tag + 32'(4*w + 2);
            e[127:96] = tag + 32'(4*w + 3);
            e[128]    = last_on_final && (w == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic go(input logic [31:0] base, input logic [31:0] len, input logic [31:0] tag);
        @(posedge clk); #1;
        job_base = base; job_tag = tag; job_beat = 0; taken = 0; rdy_cyc = 0;
        i_base_addr = base; i_total_len = len; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_count", 128'(done_cnt), 128'(target));
        repeat (4) @(negedge clk);
        check("done_no_extra", 128'(done_cnt), 128'(target));
        check("words_left", 128'(exp_q.size()), 128'(0));
        check("ar_left", 128'(exp_ar.size()), 128'(0));
    endtask

    // AXI slave: always accepts AR, streams beats back-to-back.
    initial begin : slave
        bit          rst_seen, ar_hs, r_hs, in_burst;
        logic [31:0] cur_addr, ar_addr;
        logic [39:0] ea;
        int          beat_in_burst, burst_len;
        in_burst = 0; cur_addr = '0; ar_addr = '0; beat_in_burst = 0; burst_len = 0;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            rst_seen = !rst_n;
            ar_hs    = m_axi_arvalid && m_axi_arready;
            r_hs     = m_axi_rvalid && m_axi_rready;
            if (rst_n && ar_hs) begin
                ar_addr = m_axi_araddr;
                if (exp_ar.size() == 0) check("ar_unexpected", {m_axi_araddr, m_axi_arlen}, 0);
                else begin
                    ea = exp_ar.pop_front();
                    check("ar_addr", m_axi_araddr, ea[39:8]);
                    check("ar_len", m_axi_arlen, ea[7:0]);
                end
            end
            if (rst_n && rdy_chk && m_axi_rvalid) begin
                check("rready_model", m_axi_rready, !((taken % 4 == 3) && o_valid && !i_ready));
                if (!m_axi_rready) rdy_low++;
            end
            if (rst_n && r_hs) taken++;
            @(posedge clk); #1;
            if (rst_seen) begin
                in_burst = 0;
            end else if (ar_hs) begin
                cur_addr = ar_addr; burst_len = int'(m_axi_arlen) + 1;
                beat_in_burst = 0; in_burst = 1;
            end else if (r_hs) begin
                cur_addr += 4; beat_in_burst++; job_beat++;
                if (beat_in_burst == burst_len) in_burst = 0;
            end
            m_axi_rvalid = in_burst;
            m_axi_rdata  = job_tag + ((cur_addr - job_base) >> 2);
            m_axi_rresp  = (in_burst && job_beat == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = in_burst && (beat_in_burst == burst_len - 1);
        end
    end

    // Downstream ready: always 1, or a long stall followed by 1-0-0-1 toggling.
    initial begin : ready_drv
        i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode) begin
                i_ready = (rdy_cyc < 14) ? 1'b0 : pat[(rdy_cyc - 14) % 4];
                rdy_cyc++;
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    // Output monitor: pops expected words and checks completion status.
    initial begin : monitor
        logic [128:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && o_valid && i_ready) begin
                if (exp_q.size() == 0) check("word_unexpected", o_data, 0);
                else begin
                    e = exp_q.pop_front();
                    check("word_data", o_data, e[127:0]);
                    check("word_last", o_last, e[128]);
                end
            end
            if (rst_n && o_done) begin
                done_cnt++;
                check("done_error", o_error, exp_err);
                check("done_busy", o_busy, 0);
            end
        end
    end

    initial begin : stim
        int n;
        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_total_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_arsize", m_axi_arsize, 3'b010);
        check("rst_arburst", m_axi_arburst, 2'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single 16-beat burst.
        exp_ar.push_back({32'h0000_1000, 8'd15});
        push_words(32'h0, 4, 1'b1);
        go(32'h0000_1000, 32'd64, 32'h0);
        wait_done(1);

        // Burst split at the 4 KB boundary.
        exp_ar.push_back({32'h0000_0FF0, 8'd3});
        exp_ar.push_back({32'h0000_1000, 8'd11});
        push_words(32'h200, 4, 1'b1);
        go(32'h0000_0FF0, 32'd64, 32'h200);
        wait_done(2);

        // 20 beats split by MAX_BURST, with output backpressure.
        exp_ar.push_back({32'h0000_2000, 8'd15});
        exp_ar.push_back({32'h0000_2040, 8'd3});
        push_words(32'h300, 5, 1'b1);
        rdy_low = 0; rdy_chk = 1'b1; rdy_mode = 1'b1;
        go(32'h0000_2000, 32'd80, 32'h300);
        wait_done(3);
        rdy_chk = 1'b0; rdy_mode = 1'b0;
        check("rready_stall_seen", 128'(rdy_low != 0), 1);

        // SLVERR on the 6th beat: only word0 survives.
        err_beat = 5; exp_err = 1'b1;
        exp_ar.push_back({32'h0000_3000, 8'd15});
        push_words(32'h400, 1, 1'b0);
        go(32'h0000_3000, 32'd64, 32'h400);
        wait_done(4);
        check("error_sticky", o_error, 1);
        err_beat = -1; exp_err = 1'b0;

        // Zero whole words: done two cycles after start, no AXI traffic.
        go(32'h0000_0000, 32'h0000_000F, 32'h0);
        @(negedge clk);
        check("zero_done_early", o_done, 0);
        check("zero_busy", o_busy, 1);
        @(negedge clk);
        check("zero_done", o_done, 1);
        wait_done(5);

        // Start pulsed while busy is ignored.
        exp_ar.push_back({32'h0000_4000, 8'd7});
        push_words(32'h500, 2, 1'b1);
        go(32'h0000_4000, 32'd32, 32'h500);
        repeat (3) @(posedge clk);
        #1;
        i_base_addr = 32'h0000_7000; i_total_len = 32'd64; i_start = 1'b1;
        @(negedge clk);
        check("busy_during_restart", o_busy, 1);
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(6);

        // Reset in the middle of a burst.
        exp_ar.push_back({32'h0000_5000, 8'd15});
        go(32'h0000_5000, 32'd64, 32'h600);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_axi_rvalid && m_axi_rready) && n < 100);
        check("mid_rready", m_axi_rready, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_arvalid", m_axi_arvalid, 0);
        check("mid_rst_rready", m_axi_rready, 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_busy", o_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ar.push_back({32'h0000_6000, 8'd7});
        push_words(32'h700, 2, 1'b1);
        go(32'h0000_6000, 32'd32, 32'h700);
        wait_done(7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
